// File: rtl/lpc_pkg.sv
// Shared definitions for the passive LPC/FWH cycle decoder.
// Holds the decoder state enum, START / CT-DIR / SYNC / MSIZE field codes, and small
// helpers used by the FSM in lpc_cycle_decoder.
package lpc_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StIgnore,
    StCtDir,
    StIdsel,
    StAddr,
    StMsize,
    StWdata,
    StTar1,
    StSync,
    StRdata,
    StTar2
  } lpc_state_e;

  // START nibbles, sampled on the last clock with LFRAME# low
  localparam logic [3:0] StartLpc      = 4'b0000;
  localparam logic [3:0] StartFwhRead  = 4'b1101;
  localparam logic [3:0] StartFwhWrite = 4'b1110;
  localparam logic [3:0] StartAbort    = 4'b1111;

  // CT/DIR nibble bits [3:2]
  localparam logic [1:0] CtIo   = 2'b00;
  localparam logic [1:0] CtMem  = 2'b01;
  localparam logic [1:0] CtDma  = 2'b10;
  localparam logic [1:0] CtRsvd = 2'b11;

  // SYNC nibbles
  localparam logic [3:0] SyncReady     = 4'b0000;
  localparam logic [3:0] SyncShortWait = 4'b0101;
  localparam logic [3:0] SyncLongWait  = 4'b0110;
  localparam logic [3:0] SyncError     = 4'b1010;

  // FWH MSIZE nibbles
  localparam logic [3:0] Msize1 = 4'b0000;
  localparam logic [3:0] Msize2 = 4'b0001;
  localparam logic [3:0] Msize4 = 4'b0010;

  // Byte count for an MSIZE code; 0 marks an unsupported code.
  function automatic logic [3:0] msize_bytes(input logic [3:0] msize);
    logic [3:0] bytes;
    case (msize)
      Msize1:  bytes = 4'd1;
      Msize2:  bytes = 4'd2;
      Msize4:  bytes = 4'd4;
      default: bytes = 4'd0;
    endcase
    return bytes;
  endfunction

  // States that have committed to a cycle; a START seen here is an abort.
  function automatic logic past_header(input lpc_state_e st);
    return st inside {StAddr, StMsize, StWdata, StTar1, StSync, StRdata, StTar2};
  endfunction

endpackage

// File: rtl/lpc_nibble_shift.sv
// Nibble accumulator with a nibble counter.
// MSB-first mode shifts each nibble in at the bottom (address fields); LSB-first mode
// deposits the nibble at the position given by the counter, so a short transfer leaves the
// upper nibbles at zero (data fields).
// Ports: clk/rst (sync, active-high), clear (zero value and count), shift (accept nibble),
// lsb_first (mode), nibble (input), value (accumulated bits), count (nibbles accepted).
module lpc_nibble_shift #(
  parameter int unsigned NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   shift,
  input  logic                   lsb_first,
  input  logic [3:0]             nibble,
  output logic [4*NIBBLES-1:0]   value,
  output logic [3:0]             count
);

  logic [4*NIBBLES-1:0] value_q, value_d;
  logic [3:0]           count_q, count_d;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clear) begin
      value_d = '0;
      count_d = '0;
    end else if (shift) begin
      if (lsb_first) begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (count_q == 4'(i)) value_d[4*i +: 4] = nibble;
        end
      end else begin
        value_d = {value_q[4*NIBBLES-5:0], nibble};
      end
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value = value_q;
  assign count = count_q;

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC bus sniffer: decodes IO, memory and FWH read/write cycles from LAD/LFRAME#
// and emits one registered result strobe per completed cycle.
// Ports:
//   lpc_clock, lpc_reset      - bus clock, synchronous active-high reset
//   lpc_ad, lpc_frame         - LAD[3:0] and LFRAME# pin levels
//   out_cyctype_dir           - CT/DIR nibble (LPC) or START code (FWH)
//   out_addr, out_data        - decoded address and data (byte 0 in [7:0])
//   out_data_size, out_sync   - byte count and final SYNC nibble
//   out_idsel                 - FWH IDSEL, 0 for LPC cycles
//   out_clock_enable          - one-cycle result strobe
//   out_abort                 - one-cycle abort/timeout pulse
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 4,
  parameter bit          ENABLE_FWH     = 1'b1,
  parameter int unsigned WAIT_TIMEOUT   = 1024
) (
  input  logic                        lpc_clock,
  input  logic                        lpc_reset,
  input  logic [3:0]                  lpc_ad,
  input  logic                        lpc_frame,
  output logic [3:0]                  out_cyctype_dir,
  output logic [31:0]                 out_addr,
  output logic [8*MAX_DATA_BYTES-1:0] out_data,
  output logic [3:0]                  out_data_size,
  output logic [3:0]                  out_sync,
  output logic [3:0]                  out_idsel,
  output logic                        out_clock_enable,
  output logic                        out_abort
);

  localparam int unsigned DataW = 8 * MAX_DATA_BYTES;
  localparam int unsigned WaitW = $clog2(WAIT_TIMEOUT + 1);

  lpc_state_e state_q, state_d;
  logic [3:0] ctdir_q, ctdir_d;
  logic [3:0] idsel_q, idsel_d;
  logic [3:0] addr_len_q, addr_len_d;
  logic [3:0] size_q, size_d;
  logic [3:0] sync_q, sync_d;
  logic       is_fwh_q, is_fwh_d;
  logic       is_write_q, is_write_d;
  logic       tar_q, tar_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic [3:0]       result_ctdir_q, result_size_q, result_sync_q, result_idsel_q;
  logic [31:0]      result_addr_q;
  logic [DataW-1:0] result_data_q;
  logic             strobe_q, abort_q;

  logic             addr_clear, addr_shift, data_clear, data_shift;
  logic [31:0]      addr_value;
  logic [DataW-1:0] data_value;
  logic [3:0]       addr_count, data_count;
  logic             done, abort;
  logic [3:0]       msize_n;

  lpc_nibble_shift #(
    .NIBBLES(8)
  ) u_addr_shift (
    .clk      (lpc_clock),
    .rst      (lpc_reset),
    .clear    (addr_clear),
    .shift    (addr_shift),
    .lsb_first(1'b0),
    .nibble   (lpc_ad),
    .value    (addr_value),
    .count    (addr_count)
  );

  lpc_nibble_shift #(
    .NIBBLES(2 * MAX_DATA_BYTES)
  ) u_data_shift (
    .clk      (lpc_clock),
    .rst      (lpc_reset),
    .clear    (data_clear),
    .shift    (data_shift),
    .lsb_first(1'b1),
    .nibble   (lpc_ad),
    .value    (data_value),
    .count    (data_count)
  );

  always_comb begin
    state_d    = state_q;
    ctdir_d    = ctdir_q;
    idsel_d    = idsel_q;
    addr_len_d = addr_len_q;
    size_d     = size_q;
    sync_d     = sync_q;
    is_fwh_d   = is_fwh_q;
    is_write_d = is_write_q;
    tar_d      = tar_q;
    wait_d     = wait_q;
    addr_clear = 1'b0;
    addr_shift = 1'b0;
    data_clear = 1'b0;
    data_shift = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    msize_n    = msize_bytes(lpc_ad);

    unique case (state_q)
      StIdle, StIgnore: begin
      end
      StCtDir: begin
        ctdir_d    = lpc_ad;
        is_write_d = lpc_ad[1];
        size_d     = 4'd1;
        case (lpc_ad[3:2])
          CtIo: begin
            addr_len_d = 4'd4;
            state_d    = StAddr;
          end
          CtMem: begin
            addr_len_d = 4'd8;
            state_d    = StAddr;
          end
          CtDma, CtRsvd: state_d = StIgnore;
        endcase
      end
      StIdsel: begin
        idsel_d    = lpc_ad;
        addr_len_d = 4'd7;
        state_d    = StAddr;
      end
      StAddr: begin
        addr_shift = 1'b1;
        if (addr_count == addr_len_q - 4'd1) begin
          if (is_fwh_q)        state_d = StMsize;
          else if (is_write_q) state_d = StWdata;
          else                 state_d = StTar1;
        end
      end
      StMsize: begin
        if (msize_n != 4'd0 && 32'(msize_n) <= MAX_DATA_BYTES) begin
          size_d  = msize_n;
          state_d = is_write_q ? StWdata : StTar1;
        end else begin
          state_d = StIgnore;
        end
      end
      StWdata, StRdata: begin
        data_shift = 1'b1;
        if (data_count == 4'((size_q << 1) - 4'd1)) begin
          state_d = (state_q == StWdata) ? StTar1 : StTar2;
        end
      end
      StTar1: begin
        tar_d = ~tar_q;
        if (tar_q) state_d = StSync;
      end
      StSync: begin
        wait_d = '0;
        case (lpc_ad)
          SyncShortWait: begin
          end
          SyncLongWait: begin
            if (wait_q == WaitW'(WAIT_TIMEOUT - 1)) begin
              abort   = 1'b1;
              state_d = StIdle;
            end else begin
              wait_d = wait_q + 1'b1;
            end
          end
          SyncReady, SyncError: begin
            sync_d  = lpc_ad;
            state_d = is_write_q ? StTar2 : StRdata;
          end
          default: begin
            abort   = 1'b1;
            state_d = StIdle;
          end
        endcase
      end
      StTar2: begin
        tar_d = ~tar_q;
        if (tar_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A START overrides whatever the state decode chose; a cycle finishing on this very
    // clock still completes and is not counted as aborted.
    if (!lpc_frame) begin
      abort      = past_header(state_q) && !done;
      addr_clear = 1'b1;
      data_clear = 1'b1;
      addr_shift = 1'b0;
      data_shift = 1'b0;
      tar_d      = 1'b0;
      wait_d     = '0;
      idsel_d    = '0;
      is_fwh_d   = 1'b0;
      case (lpc_ad)
        StartLpc: state_d = StCtDir;
        StartFwhRead, StartFwhWrite: begin
          if (ENABLE_FWH) begin
            state_d    = StIdsel;
            is_fwh_d   = 1'b1;
            is_write_d = (lpc_ad == StartFwhWrite);
            ctdir_d    = lpc_ad;
          end else begin
            state_d = StIgnore;
          end
        end
        StartAbort: state_d = StIdle;
        default:    state_d = StIgnore;
      endcase
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q        <= StIdle;
      ctdir_q        <= '0;
      idsel_q        <= '0;
      addr_len_q     <= '0;
      size_q         <= '0;
      sync_q         <= '0;
      is_fwh_q       <= 1'b0;
      is_write_q     <= 1'b0;
      tar_q          <= 1'b0;
      wait_q         <= '0;
      result_ctdir_q <= '0;
      result_addr_q  <= '0;
      result_data_q  <= '0;
      result_size_q  <= '0;
      result_sync_q  <= '0;
      result_idsel_q <= '0;
      strobe_q       <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctdir_q    <= ctdir_d;
      idsel_q    <= idsel_d;
      addr_len_q <= addr_len_d;
      size_q     <= size_d;
      sync_q     <= sync_d;
      is_fwh_q   <= is_fwh_d;
      is_write_q <= is_write_d;
      tar_q      <= tar_d;
      wait_q     <= wait_d;
      strobe_q   <= done;
      abort_q    <= abort;
      if (done) begin
        result_ctdir_q <= ctdir_q;
        result_addr_q  <= addr_value;
        result_data_q  <= data_value;
        result_size_q  <= size_q;
        result_sync_q  <= sync_q;
        result_idsel_q <= idsel_q;
      end
    end
  end

  assign out_cyctype_dir  = result_ctdir_q;
  assign out_addr         = result_addr_q;
  assign out_data         = result_data_q;
  assign out_data_size    = result_size_q;
  assign out_sync         = result_sync_q;
  assign out_idsel        = result_idsel_q;
  assign out_clock_enable = strobe_q;
  assign out_abort        = abort_q;

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Self-checking bench for lpc_cycle_decoder: directed cycles, abort/timeout/reset cases and
// randomized IO/memory/FWH transactions checked against expectations built from the bus
// protocol rules.
module tb_lpc_cycle_decoder;

  localparam int KIo  = 0;
  localparam int KMem = 1;
  localparam int KFwh = 2;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset = 1'b1;
  logic [3:0]  lpc_ad    = 4'h0;
  logic        lpc_frame = 1'b1;
  logic [3:0]  out_cyctype_dir, out_data_size, out_sync, out_idsel;
  logic [31:0] out_addr, out_data;
  logic        out_clock_enable, out_abort;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int aborts   = 0;

  logic [31:0] exp_addr, exp_data;
  logic [3:0]  exp_ctdir, exp_size, exp_sync, exp_idsel;

  lpc_cycle_decoder #(
    .MAX_DATA_BYTES(4),
    .ENABLE_FWH    (1'b1),
    .WAIT_TIMEOUT  (1024)
  ) dut (
    .lpc_clock       (lpc_clock),
    .lpc_reset       (lpc_reset),
    .lpc_ad          (lpc_ad),
    .lpc_frame       (lpc_frame),
    .out_cyctype_dir (out_cyctype_dir),
    .out_addr        (out_addr),
    .out_data        (out_data),
    .out_data_size   (out_data_size),
    .out_sync        (out_sync),
    .out_idsel       (out_idsel),
    .out_clock_enable(out_clock_enable),
    .out_abort       (out_abort)
  );

  always #5 lpc_clock = ~lpc_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus clock; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic frame, input logic [3:0] ad);
    lpc_frame = frame;
    lpc_ad    = ad;
    @(posedge lpc_clock);
    #1;
    if (out_clock_enable === 1'b1) strobes++;
    if (out_abort === 1'b1) aborts++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ctdir"}, 32'(out_cyctype_dir), 32'h0);
    check({tag, ".addr"}, out_addr, 32'h0);
    check({tag, ".data"}, out_data, 32'h0);
    check({tag, ".size"}, 32'(out_data_size), 32'h0);
    check({tag, ".sync"}, 32'(out_sync), 32'h0);
    check({tag, ".idsel"}, 32'(out_idsel), 32'h0);
    check({tag, ".ce"}, 32'(out_clock_enable), 32'h0);
    check({tag, ".abort"}, 32'(out_abort), 32'h0);
  endtask

  task automatic check_result(input string tag, input int exp_strobes, input int exp_aborts);
    check({tag, ".strobes"}, 32'(strobes), 32'(exp_strobes));
    check({tag, ".aborts"}, 32'(aborts), 32'(exp_aborts));
    check({tag, ".ctdir"}, 32'(out_cyctype_dir), 32'(exp_ctdir));
    check({tag, ".addr"}, out_addr, exp_addr);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".size"}, 32'(out_data_size), 32'(exp_size));
    check({tag, ".sync"}, 32'(out_sync), 32'(exp_sync));
    check({tag, ".idsel"}, 32'(out_idsel), 32'(exp_idsel));
  endtask

  task automatic send_bytes(input logic [31:0] data, input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      drive(1'b1, data[8*b +: 4]);
      drive(1'b1, data[8*b+4 +: 4]);
    end
  endtask

  // wait_mode: 0 random short/long mix, 1 short only, 2 long only
  task automatic send_cycle(input string tag, input int kind, input bit wr,
                            input logic [31:0] addr, input logic [31:0] data, input int nbytes,
                            input logic [3:0] idsel, input int nwait, input int wait_mode,
                            input logic [3:0] fsync, input bit idle);
    int naddr;
    strobes = 0;
    aborts  = 0;
    naddr   = (kind == KIo) ? 4 : (kind == KMem) ? 8 : 7;

    exp_ctdir = (kind == KFwh) ? (wr ? 4'b1110 : 4'b1101)
                               : {(kind == KMem) ? 2'b01 : 2'b00, wr, 1'b0};
    exp_addr  = (kind == KIo) ? {16'h0, addr[15:0]} :
                (kind == KMem) ? addr : {4'h0, addr[27:0]};
    exp_data  = (nbytes == 4) ? data : (nbytes == 2) ? {16'h0, data[15:0]}
                                                     : {24'h0, data[7:0]};
    exp_size  = 4'(nbytes);
    exp_sync  = fsync;
    exp_idsel = (kind == KFwh) ? idsel : 4'h0;

    if (kind == KFwh) begin
      drive(1'b0, exp_ctdir);
      drive(1'b1, idsel);
    end else begin
      drive(1'b0, 4'h0);
      drive(1'b1, exp_ctdir);
    end
    for (int i = naddr - 1; i >= 0; i--) drive(1'b1, addr[4*i +: 4]);
    if (kind == KFwh) drive(1'b1, (nbytes == 1) ? 4'h0 : (nbytes == 2) ? 4'h1 : 4'h2);
    if (wr) send_bytes(data, nbytes);
    drive(1'b1, 4'($urandom));
    drive(1'b1, 4'($urandom));
    for (int w = 0; w < nwait; w++) begin
      if (wait_mode == 1)      drive(1'b1, 4'h5);
      else if (wait_mode == 2) drive(1'b1, 4'h6);
      else                     drive(1'b1, ($urandom_range(0, 1) == 0) ? 4'h5 : 4'h6);
    end
    drive(1'b1, fsync);
    if (!wr) send_bytes(data, nbytes);
    drive(1'b1, 4'($urandom));
    drive(1'b1, 4'($urandom));
    if (idle) drive(1'b1, 4'($urandom));
    check_result(tag, 1, 0);
  endtask

  initial begin
    int kind, nbytes;
    bit wr;

    // Reset state
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    check_zero("reset");
    lpc_reset = 1'b0;
    drive(1'b1, 4'h0);

    // Directed cycles
    send_cycle("io_wr", KIo, 1'b1, 32'h7fe5, 32'h6c, 1, 4'h0, 0, 0, 4'h0, 1'b1);
    send_cycle("io_rd", KIo, 1'b0, 32'h0080, 32'ha5, 1, 4'h0, 3, 1, 4'h0, 1'b1);
    send_cycle("io_rd_err", KIo, 1'b0, 32'h0080, 32'ha5, 1, 4'h0, 3, 1, 4'ha, 1'b1);
    send_cycle("mem_wr", KMem, 1'b1, 32'hffbc1234, 32'h3e, 1, 4'h0, 0, 0, 4'h0, 1'b1);
    send_cycle("fwh_rd", KFwh, 1'b0, 32'h0fff0010, 32'h44332211, 4, 4'h0, 0, 0, 4'h0, 1'b1);

    // Abort by START 1111 during the address phase; previous result must hold
    strobes = 0;
    aborts  = 0;
    drive(1'b0, 4'h0);
    drive(1'b1, 4'h2);
    drive(1'b1, 4'h7);
    drive(1'b1, 4'hf);
    drive(1'b0, 4'hf);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    check_result("abort", 0, 1);
    send_cycle("after_abort", KIo, 1'b1, 32'h1234, 32'h5a, 1, 4'h0, 0, 0, 4'h0, 1'b1);

    // DMA cycle is ignored: no strobe, no abort on the following START
    strobes = 0;
    aborts  = 0;
    drive(1'b0, 4'h0);
    drive(1'b1, 4'h8);
    for (int i = 0; i < 6; i++) drive(1'b1, 4'h3);
    check_result("dma_ignored", 0, 0);
    send_cycle("after_dma", KMem, 1'b0, 32'h89abcdef, 32'h77, 1, 4'h0, 2, 0, 4'h0, 1'b0);

    // Unsupported MSIZE is ignored
    strobes = 0;
    aborts  = 0;
    drive(1'b0, 4'hd);
    drive(1'b1, 4'h1);
    for (int i = 0; i < 7; i++) drive(1'b1, 4'h9);
    drive(1'b1, 4'h3);
    for (int i = 0; i < 8; i++) drive(1'b1, 4'h0);
    check_result("msize_bad", 0, 0);

    // 1023 long waits is still legal
    send_cycle("wait_1023", KIo, 1'b0, 32'h00f0, 32'hc3, 1, 4'h0, 1023, 2, 4'h0, 1'b1);

    // 1024 consecutive long waits time out
    strobes = 0;
    aborts  = 0;
    drive(1'b0, 4'h0);
    drive(1'b1, 4'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'h4);
    drive(1'b1, 4'hf);
    drive(1'b1, 4'hf);
    for (int i = 0; i < 1023; i++) drive(1'b1, 4'h6);
    check("timeout.before", 32'(aborts), 32'h0);
    drive(1'b1, 4'h6);
    check("timeout.pulse", 32'(aborts), 32'h1);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    check_result("timeout", 0, 1);

    // Reset during write data: outputs cleared, the rest of the cycle is dropped
    strobes = 0;
    aborts  = 0;
    drive(1'b0, 4'h0);
    drive(1'b1, 4'h2);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'h1);
    drive(1'b1, 4'h9);
    lpc_reset = 1'b1;
    drive(1'b1, 4'h9);
    check_zero("reset_mid");
    lpc_reset = 1'b0;
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    check("reset_mid.strobes", 32'(strobes), 32'h0);
    check("reset_mid.aborts", 32'(aborts), 32'h0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      wr   = 1'($urandom);
      if (kind == KFwh) begin
        case ($urandom_range(0, 2))
          0:       nbytes = 1;
          1:       nbytes = 2;
          default: nbytes = 4;
        endcase
      end else begin
        nbytes = 1;
      end
      send_cycle($sformatf("rand%0d", n), kind, wr, $urandom, $urandom, nbytes,
                 4'($urandom), $urandom_range(0, 5), 0,
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'ha, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
